// File: rtl/pixie_dma_framebuffer_if.sv
// Bus bundle between the CPU/DMA snoop side, the video reader and the frame store.
// slave = frame store, master = surrounding system (CPU snoop + pixie_video).
interface pixie_dma_framebuffer_if #(
    parameter int ADDR_W = 10
);
    logic              clk_enable;
    logic [1:0]        SC;
    logic              dma_req_n;
    logic [7:0]        data_in;
    logic              frame_start;
    logic              overrun_clr;
    logic              fb_read_en;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_data;
    logic              frame_done;
    logic              short_frame;
    logic              overrun;
    logic [ADDR_W:0]   wr_count;

    modport slave (
        input  clk_enable, SC, dma_req_n, data_in, frame_start, overrun_clr,
        input  fb_read_en, fb_addr,
        output fb_data, frame_done, short_frame, overrun, wr_count
    );

    modport master (
        output clk_enable, SC, dma_req_n, data_in, frame_start, overrun_clr,
        output fb_read_en, fb_addr,
        input  fb_data, frame_done, short_frame, overrun, wr_count
    );
endinterface

// File: rtl/pixie_dma_framebuffer.sv
// Double-buffered capture of 1861 DMA-out bytes; the display bank only ever
// changes at a frame start that follows a completely written frame.
module pixie_dma_framebuffer #(
    parameter int BYTES_PER_LINE  = 8,
    parameter int LINES_PER_FRAME = 128,
    parameter int ADDR_W          = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pixie_dma_framebuffer_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FRAME_BYTES = (ADDR_W + 1)'(BYTES_PER_LINE * LINES_PER_FRAME);

    typedef enum logic {
        BANK0_WR = 1'b0,
        BANK1_WR = 1'b1
    } bank_state_t;

    bank_state_t state_reg, state_next;
    logic        wr_bank, disp_bank;

    logic [ADDR_W:0]   wr_count_reg, wr_count_next;
    logic [ADDR_W-1:0] wr_addr;
    logic              frame_done_reg, short_frame_reg, overrun_reg;
    logic [7:0]        fb_data_reg;

    logic              dma_wr, full, swap, ram_we, ram_wr_bank, overrun_set;
    logic [ADDR_W-1:0] ram_wr_addr;

    // Both banks live in one array; the bank select is the top address bit.
    logic [7:0] ram [0:2*DEPTH-1];

    assign dma_wr = bus.clk_enable & (bus.SC == 2'b10) & ~bus.dma_req_n;
    assign full   = (wr_count_reg == FRAME_BYTES);
    assign swap   = bus.frame_start & full;

    // Writes are strictly sequential, so the address is the low bits of the count.
    assign wr_addr = wr_count_reg[ADDR_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= BANK0_WR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (swap) begin
            state_next = (state_reg == BANK0_WR) ? BANK1_WR : BANK0_WR;
        end
    end

    always_comb begin
        wr_bank   = (state_reg == BANK1_WR);
        disp_bank = ~wr_bank;
    end

    // A byte arriving with frame_start opens the next frame at address 0,
    // in the bank that becomes the write bank after a swap.
    always_comb begin
        ram_we      = dma_wr & (bus.frame_start | ~full);
        ram_wr_bank = swap ? disp_bank : wr_bank;
        ram_wr_addr = bus.frame_start ? '0 : wr_addr;
        overrun_set = dma_wr & full & ~bus.frame_start;
    end

    always_comb begin
        wr_count_next = wr_count_reg;
        if (bus.frame_start) begin
            wr_count_next = (ADDR_W + 1)'(dma_wr);
        end else if (ram_we) begin
            wr_count_next = wr_count_reg + (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_count_reg    <= '0;
            frame_done_reg  <= 1'b0;
            short_frame_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            wr_count_reg    <= wr_count_next;
            frame_done_reg  <= swap;
            short_frame_reg <= bus.frame_start & ~full;
            if (overrun_set) begin
                overrun_reg <= 1'b1;
            end else if (bus.overrun_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[{ram_wr_bank, ram_wr_addr}] <= bus.data_in;
        end
    end

    // Read uses the registered disp_bank, so a swap only affects later reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fb_data_reg <= 8'h00;
        end else if (bus.fb_read_en) begin
            fb_data_reg <= ram[{disp_bank, bus.fb_addr}];
        end
    end

    assign bus.fb_data     = fb_data_reg;
    assign bus.frame_done  = frame_done_reg;
    assign bus.short_frame = short_frame_reg;
    assign bus.overrun     = overrun_reg;
    assign bus.wr_count    = wr_count_reg;
endmodule

// File: tb/tb_pixie_dma_framebuffer.sv
// Scoreboard bench for pixie_dma_framebuffer: stimulus queues expected read data
// and frame events, independent monitors compare whenever the DUT presents them.
module tb_pixie_dma_framebuffer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pixie_dma_framebuffer_if #(.ADDR_W(10)) bus ();

    pixie_dma_framebuffer #(
        .BYTES_PER_LINE (8),
        .LINES_PER_FRAME(128),
        .ADDR_W         (10)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } rd_t;

    localparam logic [1:0] EV_DONE  = 2'b01;
    localparam logic [1:0] EV_SHORT = 2'b10;

    int   n_checks = 0;
    int   n_fail   = 0;
    rd_t  rd_q[$];
    logic [1:0] ev_q[$];
    logic rd_pend = 1'b0;

    // {clk_enable, SC[1:0], dma_req_n} combinations that must not write
    logic [3:0] no_write_vec [0:4] = '{4'b1101, 4'b1010, 4'b1110, 4'b1000, 4'b0100};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat_p(input int a);
        logic [9:0] x;
        x = a[9:0];
        return x[7:0] ^ {6'd0, x[9:8]};
    endfunction

    function automatic logic [7:0] low_byte(input int a);
        logic [9:0] x;
        x = a[9:0];
        return x[7:0];
    endfunction

    // ---------------- monitors ----------------
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_pend <= 1'b0;
        else          rd_pend <= bus.fb_read_en;
    end

    always @(negedge clk) begin
        if (reset_n && rd_pend) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: read data 0x%02h with no expected entry", bus.fb_data);
            end else begin
                rd_t e;
                e = rd_q.pop_front();
                $display("read  addr=0x%03h data=0x%02h exp=0x%02h", e.addr, bus.fb_data, e.data);
                check("fb_data", {24'd0, bus.fb_data}, {24'd0, e.data});
            end
        end
        if (reset_n && (bus.frame_done || bus.short_frame)) begin
            if (ev_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL ev_unexpected: frame_done=%0b short_frame=%0b with nothing expected",
                         bus.frame_done, bus.short_frame);
            end else begin
                logic [1:0] ev;
                ev = ev_q.pop_front();
                $display("event frame_done=%0b short_frame=%0b", bus.frame_done, bus.short_frame);
                check("frame_event", {30'd0, bus.short_frame, bus.frame_done}, {30'd0, ev});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        bus.clk_enable  = 1'b1;
        bus.SC          = 2'b00;
        bus.dma_req_n   = 1'b1;
        bus.data_in     = 8'h00;
        bus.frame_start = 1'b0;
        bus.overrun_clr = 1'b0;
        bus.fb_read_en  = 1'b0;
        bus.fb_addr     = '0;
    endtask

    task automatic dma(input logic [7:0] d);
        bus.SC        = 2'b10;
        bus.dma_req_n = 1'b0;
        bus.data_in   = d;
        @(negedge clk);
        bus.SC        = 2'b00;
        bus.dma_req_n = 1'b1;
    endtask

    task automatic fstart(input logic [1:0] ev);
        bus.frame_start = 1'b1;
        ev_q.push_back(ev);
        @(negedge clk);
        bus.frame_start = 1'b0;
        repeat (2) @(negedge clk);
        check("pulse_seen", ev_q.size(), 0);
    endtask

    task automatic rd(input int a, input logic [7:0] e);
        rd_t t;
        t.addr = a[9:0];
        t.data = e;
        bus.fb_read_en = 1'b1;
        bus.fb_addr    = a[9:0];
        rd_q.push_back(t);
        @(negedge clk);
        bus.fb_read_en = 1'b0;
    endtask

    task automatic drain();
        repeat (2) @(negedge clk);
        check("rd_drained", rd_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_count", bus.wr_count, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_fb_data", bus.fb_data, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_short_frame", bus.short_frame, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // full frame into bank 0, swap, read back everything
        dma(pat_p(0));
        check("t1_first_count", bus.wr_count, 1);
        for (int a = 1; a < 1024; a++) dma(pat_p(a));
        check("t1_count", bus.wr_count, 1024);
        check("t1_overrun", bus.overrun, 0);
        fstart(EV_DONE);
        check("t1_count_cleared", bus.wr_count, 0);
        for (int a = 0; a < 1024; a++) rd(a, pat_p(a));
        drain();

        // short frame into bank 1: no swap, display unchanged
        for (int a = 0; a < 1000; a++) dma(~low_byte(a));
        check("t2_count", bus.wr_count, 1000);
        fstart(EV_SHORT);
        check("t2_count_cleared", bus.wr_count, 0);
        rd(0, pat_p(0));
        rd(512, pat_p(512));
        rd(999, pat_p(999));
        rd(1023, pat_p(1023));
        drain();

        // overrun: byte 1025 dropped, clear, set-wins-over-clear
        for (int a = 0; a < 1024; a++) dma(low_byte(a) ^ 8'h3C);
        check("t3_overrun_at_full", bus.overrun, 0);
        dma(8'hEE);
        check("t3_overrun_set", bus.overrun, 1);
        check("t3_count_saturated", bus.wr_count, 1024);
        bus.overrun_clr = 1'b1;
        @(negedge clk);
        bus.overrun_clr = 1'b0;
        check("t3_overrun_clr", bus.overrun, 0);
        bus.overrun_clr = 1'b1;
        dma(8'h11);
        bus.overrun_clr = 1'b0;
        check("t3_set_wins", bus.overrun, 1);
        bus.overrun_clr = 1'b1;
        @(negedge clk);
        bus.overrun_clr = 1'b0;
        check("t3_overrun_clr2", bus.overrun, 0);

        // frame_start together with a DMA byte after a full frame
        bus.frame_start = 1'b1;
        ev_q.push_back(EV_DONE);
        dma(8'hA5);
        bus.frame_start = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_pulse_seen", ev_q.size(), 0);
        check("t4_count", bus.wr_count, 1);
        rd(0, 8'h3C);
        rd(16'h155, 8'h69);
        rd(1023, 8'hC3);
        drain();
        for (int a = 1; a < 1024; a++) dma(low_byte(a) + 8'h01);
        check("t4_fill_count", bus.wr_count, 1024);
        fstart(EV_DONE);
        rd(1023, 8'h00);
        rd(0, 8'hA5);
        rd(1, 8'h02);
        drain();

        // cycles that must not write
        for (int i = 0; i < 5; i++) begin
            bus.clk_enable = no_write_vec[i][3];
            bus.SC         = no_write_vec[i][2:1];
            bus.dma_req_n  = no_write_vec[i][0];
            bus.data_in    = 8'hFF;
            @(negedge clk);
            idle_inputs();
            check("t5_no_write", bus.wr_count, 0);
        end
        for (int i = 0; i < 3; i++) dma(8'h40 + 8'(i));
        check("t5_valid_writes", bus.wr_count, 3);
        bus.clk_enable = 1'b0;
        fstart(EV_SHORT);
        bus.clk_enable = 1'b1;
        check("t5_fs_without_enable", bus.wr_count, 0);

        // reset in the middle of a frame
        for (int i = 0; i < 300; i++) dma(8'h77);
        check("t6_count_300", bus.wr_count, 300);
        check("t6_fb_data_held", bus.fb_data, 8'h02);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_wr_count", bus.wr_count, 0);
        check("t6_async_fb_data", bus.fb_data, 0);
        check("t6_async_overrun", bus.overrun, 0);
        check("t6_async_frame_done", bus.frame_done, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd(0, 8'h77);
        drain();
        for (int a = 0; a < 1024; a++) dma(low_byte(a) ^ 8'h96);
        fstart(EV_DONE);
        rd(0, 8'h96);
        rd(16'h2AA, 8'h3C);
        rd(1023, 8'h69);
        drain();

        repeat (3) @(negedge clk);
        check("end_ev_queue_empty", ev_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
